// File: rtl/aluv_sched_pkg.sv
// Scheduler-local types and helpers shared by aluv_sched and its response FIFO.
// aluv command/dtype codes are not declared here; cmd and dtype are carried as opaque fields.
package aluv_sched_pkg;

    localparam int CMD_W   = 3;
    localparam int DTYPE_W = 3;
    localparam int STAT_W  = 16;

    typedef struct packed {
        logic gnt;
        logic id;
    } grant_t;

    // Round-robin pick: on contention rr_ptr names the winner, otherwise the lone requester wins.
    function automatic grant_t rr_pick(input logic v0, input logic v1, input logic rr_ptr);
        grant_t g;
        g.gnt = v0 | v1;
        g.id  = (v0 && v1) ? rr_ptr : v1;
        return g;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/aluv_sched_fifo.sv
// In-order response FIFO with occupancy count; head data is raw and must be qualified by valid_o.
module aluv_sched_fifo
    import aluv_sched_pkg::*;
#(
    parameter int W     = 130,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_d  = push_i ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_i  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= push_data_i;
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/aluv_sched.sv
// Round-robin issue scheduler sharing one combinational aluv between two requesters.
// Optional ALUV_SCHED_STATS_EN adds saturating grant/stall counters.
module aluv_sched
    import aluv_sched_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [CMD_W-1:0]   req0_cmd,
    input  logic [DTYPE_W-1:0] req0_dtype,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [CMD_W-1:0]   req1_cmd,
    input  logic [DTYPE_W-1:0] req1_dtype,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    output logic [DATA_W-1:0]  alu_operandA,
    output logic [DATA_W-1:0]  alu_operandB,
    output logic [CMD_W-1:0]   alu_command,
    output logic [DTYPE_W-1:0] alu_dtype,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_iszero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_iszero
`ifdef ALUV_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_grant0,
    output logic [STAT_W-1:0]  stat_grant1,
    output logic [STAT_W-1:0]  stat_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = DATA_W + 2;

    logic               issue_v_q, issue_v_d;
    logic               issue_id_q, issue_id_d;
    logic               rr_q, rr_d;
    logic [DATA_W-1:0]  opa_q, opa_d;
    logic [DATA_W-1:0]  opb_q, opb_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [DTYPE_W-1:0] dt_q, dt_d;

    logic [CW-1:0]      fifo_count;
    logic               fifo_valid;
    logic [EW-1:0]      fifo_head;
    logic               pop;
    logic [CW:0]        occ;
    logic               space;
    grant_t             grant;

    // Credit counts the op sitting in the issue stage, which lands in the FIFO next edge.
    assign pop   = rsp_valid & rsp_ready;
    assign occ   = {1'b0, fifo_count} + (CW+1)'(issue_v_q) - (CW+1)'(pop);
    assign space = occ < (CW+1)'(FIFO_DEPTH);
    assign grant = rr_pick(req0_valid & space & rst_n, req1_valid & space & rst_n, rr_q);

    assign req0_ready = grant.gnt & ~grant.id;
    assign req1_ready = grant.gnt &  grant.id;

    always_comb begin
        issue_v_d  = grant.gnt;
        issue_id_d = issue_id_q;
        rr_d       = rr_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cmd_d      = cmd_q;
        dt_d       = dt_q;
        if (grant.gnt) begin
            issue_id_d = grant.id;
            rr_d       = ~grant.id;
            opa_d      = grant.id ? req1_a     : req0_a;
            opb_d      = grant.id ? req1_b     : req0_b;
            cmd_d      = grant.id ? req1_cmd   : req0_cmd;
            dt_d       = grant.id ? req1_dtype : req0_dtype;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_v_q  <= 1'b0;
            issue_id_q <= 1'b0;
            rr_q       <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            cmd_q      <= '0;
            dt_q       <= '0;
        end else begin
            issue_v_q  <= issue_v_d;
            issue_id_q <= issue_id_d;
            rr_q       <= rr_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cmd_q      <= cmd_d;
            dt_q       <= dt_d;
        end
    end

    assign alu_operandA = opa_q;
    assign alu_operandB = opb_q;
    assign alu_command  = cmd_q;
    assign alu_dtype    = dt_q;

    aluv_sched_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (issue_v_q),
        .push_data_i ({issue_id_q, alu_iszero, alu_result}),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // Response fields read as zero whenever no valid head is presented, including during reset.
    assign rsp_valid = fifo_valid & rst_n;
    assign {rsp_id, rsp_iszero, rsp_result} = rsp_valid ? fifo_head : '0;

`ifdef ALUV_SCHED_STATS_EN
    logic [STAT_W-1:0] g0_q, g1_q, stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g0_q    <= '0;
            g1_q    <= '0;
            stall_q <= '0;
        end else begin
            if (grant.gnt && !grant.id) g0_q <= sat_inc(g0_q);
            if (grant.gnt &&  grant.id) g1_q <= sat_inc(g1_q);
            if ((req0_valid || req1_valid) && !grant.gnt) stall_q <= sat_inc(stall_q);
        end
    end

    assign stat_grant0 = g0_q;
    assign stat_grant1 = g1_q;
    assign stat_stall  = stall_q;
`endif

endmodule
